// File: rtl/mtimer_bank_pkg.sv
// Shared register map, mode encodings and CFG layout for the multi-channel machine timer.
package mtimer_bank_pkg;

    localparam int MTB_MTIME_LO  = 0;
    localparam int MTB_MTIME_HI  = 1;
    localparam int MTB_CTRL      = 2;
    localparam int MTB_STATUS    = 3;
    localparam int MTB_CH_BASE   = 4;
    localparam int MTB_CH_STRIDE = 4;

    localparam int MTB_CH_CMP_LO = 0;
    localparam int MTB_CH_CMP_HI = 1;
    localparam int MTB_CH_PERIOD = 2;
    localparam int MTB_CH_CFG    = 3;

    localparam int MTB_CFG_EN       = 0;
    localparam int MTB_CFG_MODE_LSB = 1;
    localparam int MTB_CFG_IE       = 3;

    typedef enum logic [1:0] {
        MTB_MODE_LEVEL    = 2'b00,
        MTB_MODE_ONESHOT  = 2'b01,
        MTB_MODE_PERIODIC = 2'b10,
        MTB_MODE_RSVD     = 2'b11
    } mtb_mode_e;

    // Bit order matches the CFG register: [3] ie, [2:1] mode, [0] en.
    typedef struct packed {
        logic      ie;
        mtb_mode_e mode;
        logic      en;
    } mtb_cfg_t;

endpackage

// File: rtl/mtimer_chan.sv
// One compare channel: CMP/PERIOD/CFG registers, sticky pending bit and the
// level / one-shot / periodic reload behaviour driven by the shared mtime.
module mtimer_chan
    import mtimer_bank_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] mtime_i,
    input  logic             we_cmp_lo_i,
    input  logic             we_cmp_hi_i,
    input  logic             we_period_i,
    input  logic             we_cfg_i,
    input  logic [31:0]      wdata_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cmp_o,
    output logic [31:0]      period_o,
    output mtb_cfg_t         cfg_o,
    output logic             pend_o,
    output logic             irq_o
);

    localparam int HW = CNT_W - 32;

    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [31:0]      period_q, period_d;
    mtb_cfg_t         cfg_q, cfg_d;
    logic             pend_q, pend_d;
    logic             irq_q, irq_d;
    logic             hit;

    always_comb begin
        hit      = cfg_q.en && (mtime_i >= cmp_q);
        cmp_d    = cmp_q;
        period_d = period_q;
        cfg_d    = cfg_q;
        pend_d   = pend_q;
        irq_d    = pend_q & cfg_q.ie;

        case (cfg_q.mode)
            MTB_MODE_ONESHOT: begin
                pend_d = hit | (pend_q & ~clr_i);
                if (hit) cfg_d.en = 1'b0;
            end
            MTB_MODE_PERIODIC: begin
                pend_d = hit | (pend_q & ~clr_i);
                if (hit && period_q != '0) cmp_d = cmp_q + CNT_W'(period_q);
            end
            default: pend_d = hit;
        endcase

        // Bus writes are applied last so they override reload/disable in the same cycle.
        if (we_cmp_lo_i) cmp_d = {cmp_q[CNT_W-1:32], wdata_i};
        if (we_cmp_hi_i) cmp_d = {wdata_i[HW-1:0], cmp_q[31:0]};
        if (we_period_i) period_d = wdata_i;
        if (we_cfg_i)    cfg_d = mtb_cfg_t'(wdata_i[3:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_q    <= '1;
            period_q <= '0;
            cfg_q    <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            cmp_q    <= cmp_d;
            period_q <= period_d;
            cfg_q    <= cfg_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
        end
    end

    assign cmp_o    = cmp_q;
    assign period_o = period_q;
    assign cfg_o    = cfg_q;
    assign pend_o   = pend_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/mtimer_bank.sv
// Machine-timer bank: shared mtime counter, NCH compare channels, tear-free HI read.
// Optional 8-bit prescaler in CTRL[15:8] enabled by defining MTIMER_PRESCALER_EN.
module mtimer_bank
    import mtimer_bank_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int CNT_W = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    output logic [NCH-1:0] irq_o,
    output logic          tcmp_trap_valid_o,
    input  logic          hx_valid
);

    localparam int HW = CNT_W - 32;

    logic [CNT_W-1:0] mtime_q, mtime_d;
    logic [HW-1:0]    shadow_hi_q, shadow_hi_d;
    logic             ctrl_en_q, ctrl_en_d;
    logic             trap_q, trap_d;
    logic             tick;
    logic [31:0]      ctrl_rd;
    logic             we_lo, we_hi, we_ctrl, we_status;
    logic [NCH-1:0]   pend_w;
    logic [NCH-1:0]   irq_w;
    logic [NCH-1:0][31:0] ch_rd;

    assign we_lo     = we_i && (addr_i == AW'(MTB_MTIME_LO));
    assign we_hi     = we_i && (addr_i == AW'(MTB_MTIME_HI));
    assign we_ctrl   = we_i && (addr_i == AW'(MTB_CTRL));
    assign we_status = we_i && (addr_i == AW'(MTB_STATUS));

`ifdef MTIMER_PRESCALER_EN
    logic [7:0] psc_q, psc_d, psc_cnt_q, psc_cnt_d;

    always_comb begin
        tick      = ctrl_en_q && (psc_cnt_q == psc_q);
        psc_d     = psc_q;
        psc_cnt_d = psc_cnt_q;
        if (ctrl_en_q) psc_cnt_d = tick ? 8'd0 : psc_cnt_q + 8'd1;
        if (we_ctrl) begin
            psc_d     = wdata_i[15:8];
            psc_cnt_d = 8'd0;
        end
        ctrl_rd = {16'd0, psc_q, 7'd0, ctrl_en_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q     <= 8'd0;
            psc_cnt_q <= 8'd0;
        end else begin
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
        end
    end
`else
    always_comb begin
        tick    = ctrl_en_q;
        ctrl_rd = {31'd0, ctrl_en_q};
    end
`endif

    always_comb begin
        ctrl_en_d   = we_ctrl ? wdata_i[0] : ctrl_en_q;
        trap_d      = hx_valid ? |irq_w : trap_q;
        mtime_d     = tick ? mtime_q + CNT_W'(1) : mtime_q;
        // A half-word write replaces that half and suppresses the increment.
        if (we_lo) mtime_d = {mtime_q[CNT_W-1:32], wdata_i};
        if (we_hi) mtime_d = {wdata_i[HW-1:0], mtime_q[31:0]};
        shadow_hi_d = shadow_hi_q;
        if (rd_en_i && addr_i == AW'(MTB_MTIME_LO)) shadow_hi_d = mtime_q[CNT_W-1:32];
        if (we_hi) shadow_hi_d = wdata_i[HW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q     <= '0;
            shadow_hi_q <= '0;
            ctrl_en_q   <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            shadow_hi_q <= shadow_hi_d;
            ctrl_en_q   <= ctrl_en_d;
            trap_q      <= trap_d;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [AW-1:0] BASE = AW'(MTB_CH_BASE + MTB_CH_STRIDE * k);
        logic [CNT_W-1:0] cmp_k;
        logic [63:0]      cmp64;
        logic [31:0]      period_k;
        mtb_cfg_t         cfg_k;

        mtimer_chan #(.CNT_W(CNT_W)) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .mtime_i     (mtime_q),
            .we_cmp_lo_i (we_i && addr_i == BASE + AW'(MTB_CH_CMP_LO)),
            .we_cmp_hi_i (we_i && addr_i == BASE + AW'(MTB_CH_CMP_HI)),
            .we_period_i (we_i && addr_i == BASE + AW'(MTB_CH_PERIOD)),
            .we_cfg_i    (we_i && addr_i == BASE + AW'(MTB_CH_CFG)),
            .wdata_i     (wdata_i),
            .clr_i       (we_status && wdata_i[k]),
            .cmp_o       (cmp_k),
            .period_o    (period_k),
            .cfg_o       (cfg_k),
            .pend_o      (pend_w[k]),
            .irq_o       (irq_w[k])
        );

        assign cmp64    = 64'(cmp_k);
        assign ch_rd[k] = (addr_i == BASE + AW'(MTB_CH_CMP_LO)) ? cmp64[31:0]  :
                          (addr_i == BASE + AW'(MTB_CH_CMP_HI)) ? cmp64[63:32] :
                          (addr_i == BASE + AW'(MTB_CH_PERIOD)) ? period_k     :
                          (addr_i == BASE + AW'(MTB_CH_CFG))    ? {28'd0, cfg_k} : 32'd0;
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            AW'(MTB_MTIME_LO): rdata_o = mtime_q[31:0];
            AW'(MTB_MTIME_HI): rdata_o = 32'(shadow_hi_q);
            AW'(MTB_CTRL):     rdata_o = ctrl_rd;
            AW'(MTB_STATUS):   rdata_o = 32'(pend_w);
            default:           rdata_o = '0;
        endcase
        for (int k = 0; k < NCH; k++) rdata_o = rdata_o | ch_rd[k];
    end

    assign irq_o             = irq_w;
    assign tcmp_trap_valid_o = trap_q;

endmodule

// File: tb/tb_mtimer_bank.sv
// Scoreboard bench for mtimer_bank: directed bus sequences push expected values,
// a negedge monitor pops and compares whenever an observation is presented.
module tb_mtimer_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we_i = 1'b0;
    logic        rd_en_i = 1'b0;
    logic [5:0]  addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic [31:0] rdata_o;
    logic [3:0]  irq_o;
    logic        tcmp_trap_valid_o;
    logic        hx_valid = 1'b0;

    logic        obs_vld = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [31:0] mon_act;

    mtimer_bank #(.NCH(4), .CNT_W(64), .AW(6)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .we_i              (we_i),
        .rd_en_i           (rd_en_i),
        .addr_i            (addr_i),
        .wdata_i           (wdata_i),
        .rdata_o           (rdata_o),
        .irq_o             (irq_o),
        .tcmp_trap_valid_o (tcmp_trap_valid_o),
        .hx_valid          (hx_valid)
    );

    always #5 clk = ~clk;

    // Monitor: one observation per flagged cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (obs_vld) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual %h required <entry>", rdata_o);
            end else begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    0:       mon_act = rdata_o;
                    1:       mon_act = 32'(irq_o);
                    default: mon_act = 32'(tcmp_trap_valid_o);
                endcase
                checks++;
                if (mon_act !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s actual %h required %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        we_i     = 1'b0;
        rd_en_i  = 1'b0;
        obs_vld  = 1'b0;
        hx_valid = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        we_i = 1'b1; addr_i = a; wdata_i = d;
        step();
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e, input string nm);
        rd_en_i = 1'b1; addr_i = a; obs_vld = 1'b1;
        sb.push_back('{kind: 0, exp: e, name: nm});
        step();
    endtask

    task automatic chk(input int kind, input logic [31:0] e, input string nm);
        obs_vld = 1'b1;
        sb.push_back('{kind: kind, exp: e, name: nm});
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pv [2];
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        rd(0, 32'h0, "rst_mtime_lo");
        rd(1, 32'h0, "rst_mtime_hi");
        rd(2, 32'h0, "rst_ctrl");
        rd(3, 32'h0, "rst_status");
        rd(4, 32'hFFFF_FFFF, "rst_cmp0_lo");
        rd(5, 32'hFFFF_FFFF, "rst_cmp0_hi");
        rd(6, 32'h0, "rst_period0");
        rd(7, 32'h0, "rst_cfg0");
        rd(17, 32'hFFFF_FFFF, "rst_cmp3_hi");
        rd(20, 32'h0, "unmapped_read");
        chk(1, 32'h0, "rst_irq");
        chk(2, 32'h0, "rst_trap");

        // Level mode on ch0, CMP=10
        wr(4, 10); wr(5, 0); wr(7, 32'h9); wr(0, 8);
        wr(2, 1);
        chk(1, 32'h0, "lvl_irq_m8");
        chk(1, 32'h0, "lvl_irq_m9");
        wr(3, 1);
        chk(1, 32'h0, "lvl_irq_latency");
        chk(1, 32'h1, "lvl_irq_rise");
        wr(3, 1);
        rd(3, 32'h1, "lvl_w1c_while_hit");
        chk(1, 32'h1, "lvl_irq_stays");
        wr(2, 0); wr(7, 0);
        idle(2);
        chk(1, 32'h0, "lvl_irq_off");

        // One-shot on ch1, CMP=5
        wr(0, 0); wr(1, 0); wr(8, 5); wr(9, 0); wr(11, 32'hB);
        wr(0, 5);
        idle(1);
        rd(11, 32'hA, "os_cfg_en_cleared");
        rd(3, 32'h2, "os_pend");
        chk(1, 32'h2, "os_irq");
        wr(0, 20); wr(3, 2);
        rd(3, 32'h0, "os_w1c");
        idle(3);
        rd(3, 32'h0, "os_no_refire");

        // Periodic on ch2, CMP=8, PERIOD=8
        wr(0, 0); wr(12, 8); wr(13, 0); wr(14, 8); wr(15, 32'hD);
        pv[0] = 8; pv[1] = 16;
        for (int i = 0; i < 2; i++) begin
            wr(0, pv[i]);
            idle(1);
            rd(12, pv[i] + 8, "per_cmp_reload");
            rd(3, 32'h4, "per_pend");
            wr(3, 4);
            rd(3, 32'h0, "per_w1c");
        end
        wr(0, 24);
        wr(3, 4);
        rd(12, 32'd32, "per_cmp32");
        rd(3, 32'h4, "per_set_beats_clr");
        wr(3, 4);
        rd(3, 32'h0, "per_w1c_last");
        wr(15, 0);

        // Tear-free read across the 32-bit carry
        wr(0, 32'hFFFF_FFFF); wr(1, 0);
        wr(2, 1);
        rd(0, 32'hFFFF_FFFF, "tf_lo");
        rd(1, 32'h0, "tf_hi_latched");
        wr(2, 0);
        rd(0, 32'h2, "tf_lo_after");
        rd(1, 32'h1, "tf_hi_after");
        wr(1, 5);
        rd(1, 32'h5, "hi_write_loads_shadow");
        rd(0, 32'h2, "hi_write_lo_held");

        // LO write during a tick wins over the increment
        wr(1, 0);
        wr(2, 1);
        wr(0, 100);
        rd(0, 32'd100, "lo_write_wins");
        rd(0, 32'd101, "count_resumes");
        wr(2, 0);

`ifdef MTIMER_PRESCALER_EN
        wr(0, 0); wr(1, 0);
        wr(2, 32'h301);
        idle(3);
        rd(0, 32'd0, "psc_hold");
        rd(0, 32'd1, "psc_tick1");
        idle(2);
        rd(0, 32'd1, "psc_hold2");
        rd(0, 32'd2, "psc_tick2");
        rd(2, 32'h301, "ctrl_psc_readback");
        wr(2, 0);
`else
        wr(2, 32'h300);
        rd(2, 32'h0, "ctrl_psc_ignored");
`endif

        // Trap output follows |irq_o only when hx_valid is high
        wr(0, 50); wr(1, 0);
        wr(7, 32'h9);
        idle(2);
        chk(2, 32'h0, "trap_hold_low");
        chk(1, 32'h1, "trap_irq_up");
        hx_valid = 1'b1;
        step();
        chk(2, 32'h1, "trap_set");
        wr(7, 0);
        idle(4);
        chk(1, 32'h0, "trap_irq_down");
        chk(2, 32'h1, "trap_hold_high");
        hx_valid = 1'b1;
        step();
        chk(2, 32'h0, "trap_clear");

        // Asynchronous reset mid-operation
        wr(4, 32'h77); wr(2, 1);
        idle(2);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(0, 32'h0, "arst_mtime_lo");
        rd(2, 32'h0, "arst_ctrl");
        rd(4, 32'hFFFF_FFFF, "arst_cmp0_lo");

        idle(2);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain actual %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
